// File: rtl/router_pkg.sv
// Shared state encoding and address constants for the 1x3 router input path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package router_pkg;

    // 3-bit FSM encoding; values are fixed because other router blocks decode them.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR0 = 2'd0;
    localparam logic [1:0] ADDR1 = 2'd1;
    localparam logic [1:0] ADDR2 = 2'd2;

    // Only three output channels exist; address 3 is a malformed header.
    function automatic logic addr_is_valid(input logic [1:0] a);
        return (a == ADDR0) || (a == ADDR1) || (a == ADDR2);
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Router input control FSM: decodes header address, sequences header/payload/parity/stall phases.
// Latency: state and all outputs update on the clock edge after the deciding inputs (Moore, registered).
// Backpressure: busy tells the source to hold data in every state except DECODE_ADDRESS and LOAD_DATA.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   pkt_valid, data_in[1:0]        source packet strobe and header address bits
//   fifo_full                      selected destination FIFO full
//   fifo_empty_0..2                per-channel FIFO empty
//   soft_reset_0..2                per-channel read-timeout soft reset
//   parity_done, low_pkt_valid     status from the packet register datapath
//   detect_add .. rst_int_reg      one-hot style state indications
//   write_enb_reg, busy            FIFO write enable and source hold request
module router_fsm
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_q;

    logic       empty_sel_q;   // fifo_empty of the latched channel
    logic       soft_rst_sel;  // soft_reset of the latched channel
    logic       empty_sel_in;  // fifo_empty of the channel named by the incoming header

    // Channel selection on the latched address (address 3 selects nothing).
    always_comb begin
        empty_sel_q  = 1'b0;
        soft_rst_sel = 1'b0;
        case (addr_q)
            ADDR0: begin empty_sel_q = fifo_empty_0; soft_rst_sel = soft_reset_0; end
            ADDR1: begin empty_sel_q = fifo_empty_1; soft_rst_sel = soft_reset_1; end
            ADDR2: begin empty_sel_q = fifo_empty_2; soft_rst_sel = soft_reset_2; end
            default: begin empty_sel_q = 1'b0; soft_rst_sel = 1'b0; end
        endcase
    end

    // Separate selection on the live header bits, used only while decoding.
    always_comb begin
        empty_sel_in = 1'b0;
        case (data_in)
            ADDR0:   empty_sel_in = fifo_empty_0;
            ADDR1:   empty_sel_in = fifo_empty_1;
            ADDR2:   empty_sel_in = fifo_empty_2;
            default: empty_sel_in = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && addr_is_valid(data_in))
                    next_state = empty_sel_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                // A full FIFO beats the end of packet; low_pkt_valid recovers the parity path later.
                if (fifo_full)       next_state = FIFO_FULL_STATE;
                else if (!pkt_valid) next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        next_state = DECODE_ADDRESS;
                else if (low_pkt_valid) next_state = LOAD_PARITY;
                else                    next_state = LOAD_DATA;
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (empty_sel_q) next_state = LOAD_FIRST_DATA;
            end
            default: next_state = DECODE_ADDRESS;
        endcase
        // A read timeout on our own channel abandons the packet from any state.
        if (soft_rst_sel)
            next_state = DECODE_ADDRESS;
    end

    // Outputs are registered as a decode of the next state, so they always match
    // the registered state and have no combinational path from inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= DECODE_ADDRESS;
            addr_q        <= ADDR0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr_q <= data_in;
            detect_add    <= (next_state == DECODE_ADDRESS);
            lfd_state     <= (next_state == LOAD_FIRST_DATA);
            ld_state      <= (next_state == LOAD_DATA);
            laf_state     <= (next_state == LOAD_AFTER_FULL);
            full_state    <= (next_state == FIFO_FULL_STATE);
            rst_int_reg   <= (next_state == CHECK_PARITY_ERROR);
            write_enb_reg <= (next_state == LOAD_DATA) || (next_state == LOAD_PARITY) ||
                             (next_state == LOAD_AFTER_FULL);
            busy          <= !((next_state == DECODE_ADDRESS) || (next_state == LOAD_DATA));
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b1, fifo_empty_1 = 1'b1, fifo_empty_2 = 1'b1;
    logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0, low_pkt_valid = 1'b0;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;

    int n_tests = 0;
    int n_fail  = 0;

    router_fsm dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Packet phases named by what the router is doing with the byte stream.
    typedef enum int {M_IDLE, M_WAIT, M_HDR, M_PAY, M_STALL, M_RESUME, M_PAR, M_CHK} mph_t;
    mph_t       m_ph;
    int         m_addr;
    logic [2:0] m_emp, m_srs;
    mph_t       m_nx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph   = M_IDLE;
            m_addr = 0;
        end else begin
            m_emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
            m_srs = {soft_reset_2, soft_reset_1, soft_reset_0};
            m_nx  = m_ph;
            case (m_ph)
                M_IDLE:   if (pkt_valid && data_in != 2'd3)
                              m_nx = m_emp[data_in] ? M_HDR : M_WAIT;
                M_WAIT:   if (m_addr < 3 && m_emp[m_addr]) m_nx = M_HDR;
                M_HDR:    m_nx = M_PAY;
                M_PAY:    m_nx = fifo_full ? M_STALL : (pkt_valid ? M_PAY : M_PAR);
                M_STALL:  m_nx = fifo_full ? M_STALL : M_RESUME;
                M_RESUME: m_nx = parity_done ? M_IDLE : (low_pkt_valid ? M_PAR : M_PAY);
                M_PAR:    m_nx = M_CHK;
                M_CHK:    m_nx = fifo_full ? M_STALL : M_IDLE;
                default:  m_nx = M_IDLE;
            endcase
            if (m_addr < 3 && m_srs[m_addr]) m_nx = M_IDLE;
            if (m_ph == M_IDLE && pkt_valid) m_addr = int'(data_in);
            m_ph = m_nx;
        end
    end

    function automatic logic [7:0] expect_outs(input mph_t p);
        logic [7:0] v;
        // {detect, lfd, ld, laf, full, rst_int, write_enb, busy}
        v[7] = (p == M_IDLE);
        v[6] = (p == M_HDR);
        v[5] = (p == M_PAY);
        v[4] = (p == M_RESUME);
        v[3] = (p == M_STALL);
        v[2] = (p == M_CHK);
        v[1] = (p == M_PAY) || (p == M_PAR) || (p == M_RESUME);
        v[0] = !((p == M_IDLE) || (p == M_PAY));
        return v;
    endfunction

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        chk("cycle_outputs",
            {24'd0, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy},
            {24'd0, expect_outs(m_ph)});
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_detect_add", detect_add, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_write_enb", write_enb_reg, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Normal packet: header 8'h2A -> addr 2, 10 payload bytes.
        pkt_valid = 1'b1; data_in = 2'd2;
        step();
        chk("norm_lfd", lfd_state, 1'b1);
        chk("norm_lfd_busy", busy, 1'b1);
        step();
        for (int i = 1; i <= 10; i++) begin
            chk("norm_ld", {ld_state, write_enb_reg, busy}, 3'b110);
            if (i == 10) pkt_valid = 1'b0;
            step();
        end
        chk("norm_parity", {ld_state, write_enb_reg, busy, rst_int_reg}, 4'b0110);
        step();
        chk("norm_chk_parity", {rst_int_reg, busy, write_enb_reg}, 3'b110);
        step();
        chk("norm_back_decode", detect_add, 1'b1);

        // Destination busy on channel 1.
        fifo_empty_1 = 1'b0; pkt_valid = 1'b1; data_in = 2'd1;
        step();
        pkt_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("wait_busy", {busy, write_enb_reg, lfd_state, detect_add}, 4'b1000);
            if (i == 4) fifo_empty_1 = 1'b1;
            step();
        end
        chk("wait_release_lfd", lfd_state, 1'b1);
        step();
        chk("wait_ld", ld_state, 1'b1);
        step(); step(); step();
        chk("wait_pkt_done", detect_add, 1'b1);

        // FIFO stall at 4th payload byte, resume into payload, then low_pkt_valid variant.
        for (int v = 0; v < 2; v++) begin
            pkt_valid = 1'b1; data_in = 2'd0;
            step(); step();
            for (int i = 1; i <= 4; i++) begin
                if (i == 4) fifo_full = 1'b1;
                step();
            end
            for (int i = 0; i < 3; i++) begin
                chk("stall_full", {full_state, busy, write_enb_reg}, 3'b110);
                if (i == 2) fifo_full = 1'b0;
                step();
            end
            chk("stall_laf", laf_state, 1'b1);
            if (v == 1) begin pkt_valid = 1'b0; low_pkt_valid = 1'b1; end
            step();
            low_pkt_valid = 1'b0;
            if (v == 0) begin
                chk("stall_resume_ld", ld_state, 1'b1);
                pkt_valid = 1'b0;
                step();
            end
            chk("stall_parity", {write_enb_reg, busy, ld_state, laf_state}, 4'b1100);
            step(); step();
            chk("stall_done", detect_add, 1'b1);
        end

        // Invalid address 3.
        pkt_valid = 1'b1; data_in = 2'd3;
        step();
        chk("addr3_stay", {detect_add, lfd_state}, 2'b10);
        step();
        chk("addr3_stay2", {detect_add, lfd_state, busy}, 3'b100);

        // Soft resets during a channel-2 packet.
        data_in = 2'd2;
        step(); step();
        chk("sr_in_ld", ld_state, 1'b1);
        soft_reset_0 = 1'b1;
        step();
        soft_reset_0 = 1'b0;
        chk("sr_other_ignored", ld_state, 1'b1);
        soft_reset_2 = 1'b1; pkt_valid = 1'b0;
        step();
        soft_reset_2 = 1'b0;
        chk("sr_own_decode", detect_add, 1'b1);

        // Asynchronous reset mid-payload, then a fresh header.
        pkt_valid = 1'b1; data_in = 2'd1;
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk("arst_mid_ld", {detect_add, busy, write_enb_reg}, 3'b100);
        step();
        rst = 1'b0;
        pkt_valid = 1'b1; data_in = 2'd0;
        step();
        chk("arst_next_header", lfd_state, 1'b1);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            pkt_valid     = ($urandom_range(99) < 75);
            data_in       = 2'($urandom_range(3));
            fifo_full     = ($urandom_range(99) < 20);
            fifo_empty_0  = ($urandom_range(99) < 70);
            fifo_empty_1  = ($urandom_range(99) < 70);
            fifo_empty_2  = ($urandom_range(99) < 70);
            soft_reset_0  = ($urandom_range(99) < 3);
            soft_reset_1  = ($urandom_range(99) < 3);
            soft_reset_2  = ($urandom_range(99) < 3);
            parity_done   = ($urandom_range(99) < 20);
            low_pkt_valid = ($urandom_range(99) < 20);
            rst           = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
